// File: rtl/stall_read_response_buffer_pkg.sv
// Shared defaults and width helper for the stall read-response buffer.
package stall_read_response_buffer_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    // Number of bits needed to index 'value' distinct items (minimum 1).
    function automatic int clog2(input int value);
        int r_bits;
        int r_rem;
        r_bits = 0;
        r_rem  = value - 1;
        while (r_rem > 0) begin
            r_bits++;
            r_rem = r_rem >> 1;
        end
        return (r_bits < 1) ? 1 : r_bits;
    endfunction

endpackage

// File: rtl/stall_read_response_buffer_if.sv
// Datapath-side and RAM-side signals of the stall read-response buffer.
interface stall_read_response_buffer_if
    import stall_read_response_buffer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              global_stall;
    logic              core_ren;
    logic [ADDR_W-1:0] core_raddr;
    logic [DATA_W-1:0] core_rdata;
    logic              core_rdata_valid;
    logic              core_req_ready;
    logic              core_wen;
    logic [ADDR_W-1:0] core_waddr;
    logic [DATA_W-1:0] core_wdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              overflow;

    // Buffer side.
    modport slave (
        input  global_stall, core_ren, core_raddr, core_wen, core_waddr,
               core_wdata, mem_rdata,
        output core_rdata, core_rdata_valid, core_req_ready, mem_raddr,
               mem_wen, mem_waddr, mem_wdata, overflow
    );

    // Datapath plus RAM side.
    modport master (
        output global_stall, core_ren, core_raddr, core_wen, core_waddr,
               core_wdata, mem_rdata,
        input  core_rdata, core_rdata_valid, core_req_ready, mem_raddr,
               mem_wen, mem_waddr, mem_wdata, overflow
    );

endinterface

// File: rtl/stall_read_response_buffer_resp_fifo.sv
// Synchronous FIFO holding read data that returned while the datapath was stalled.
module stall_read_response_buffer_resp_fifo
    import stall_read_response_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_rdata,
    output logic [clog2(DEPTH+1)-1:0]  o_count,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PTR_W'(1);
            if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/stall_read_response_buffer.sv
// Stall-tolerant read-response buffer between an HLS datapath and a single-port RAM.
module stall_read_response_buffer
    import stall_read_response_buffer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    stall_read_response_buffer_if.slave bus
);

    localparam int CNT_W = clog2(DEPTH + 1);

    logic [RD_LAT-1:0] r_tag_p;
    logic [CNT_W-1:0]  r_in_flight;
    logic              r_overflow;
    logic [DATA_W-1:0] r_last_data;

    logic [ADDR_W-1:0] w_raddr;
    logic              w_arrive;
    logic              w_ready;
    logic              w_accept;
    logic              w_pop;
    logic              w_push_req;
    logic              w_push;
    logic              w_deliver;
    logic [DATA_W-1:0] w_dlv_data;
    logic [DATA_W-1:0] w_fifo_rdata;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_empty;
    logic              w_fifo_full;

    // Request side: the RAM address is a straight pass-through.
    assign w_raddr       = bus.core_raddr;
    assign bus.mem_raddr = w_raddr;
    assign w_arrive      = r_tag_p[RD_LAT-1];
    assign w_ready       = ({1'b0, r_in_flight} + {1'b0, w_fifo_count}) < (CNT_W + 1)'(DEPTH);
    assign w_accept      = !rst && bus.core_ren && !bus.global_stall && w_ready;

    // Response side: FIFO head has priority so delivery stays in issue order;
    // reset suppresses any response already in the RAM pipeline.
    assign w_pop      = !rst && !bus.global_stall && !w_fifo_empty;
    assign w_push_req = !rst && w_arrive && (bus.global_stall || !w_fifo_empty);
    assign w_push     = w_push_req && !w_fifo_full;
    assign w_deliver  = !rst && !bus.global_stall && (!w_fifo_empty || w_arrive);
    assign w_dlv_data = w_fifo_empty ? bus.mem_rdata : w_fifo_rdata;

    assign bus.core_rdata       = w_deliver ? w_dlv_data : r_last_data;
    assign bus.core_rdata_valid = w_deliver;
    assign bus.core_req_ready   = w_ready;
    assign bus.overflow         = r_overflow;

    // Writes are blocked while stalled so a frozen datapath cannot store twice.
    assign bus.mem_wen   = bus.core_wen && !bus.global_stall;
    assign bus.mem_waddr = bus.core_waddr;
    assign bus.mem_wdata = bus.core_wdata;

    stall_read_response_buffer_resp_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (bus.mem_rdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // Tag pipeline: one accept bit per cycle, advancing even while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_p <= '0;
        end else begin
            r_tag_p[0] <= w_accept;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_p[i] <= r_tag_p[i-1];
            end
        end
    end

    // Count of accepted reads whose data has not yet come back from the RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_flight <= '0;
        end else begin
            case ({w_accept, w_arrive})
                2'b10:   r_in_flight <= r_in_flight + CNT_W'(1);
                2'b01:   r_in_flight <= r_in_flight - CNT_W'(1);
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    // Sticky flag for a dropped read request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (bus.core_ren && !bus.global_stall && !w_ready) begin
            r_overflow <= 1'b1;
        end
    end

    // Last delivered word, held on core_rdata while nothing is delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_data <= '0;
        end else if (w_deliver) begin
            r_last_data <= w_dlv_data;
        end
    end

endmodule

// File: tb/tb_stall_read_response_buffer.sv
// Directed bench: table-driven cycles on a RD_LAT=1 instance and hand
// sequences on a RD_LAT=4 instance for fill, overflow and reset cases.
module tb_stall_read_response_buffer;
    import stall_read_response_buffer_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst1;
    logic rst2;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    stall_read_response_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    stall_read_response_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

    stall_read_response_buffer #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .DEPTH(4)) u_dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    stall_read_response_buffer #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(4), .DEPTH(4)) u_dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    // RAM models: contents mem[i] = 10*i loaded during reset.
    logic [DW-1:0] mem1 [32];
    logic [DW-1:0] mem2 [32];
    logic [DW-1:0] rd1_p;
    logic [DW-1:0] rd2_p [4];

    always @(posedge clk) begin
        if (rst1) begin
            for (int i = 0; i < 32; i++) mem1[i] <= DW'(i * 10);
        end else if (bus1.mem_wen) begin
            mem1[bus1.mem_waddr] <= bus1.mem_wdata;
        end
        rd1_p <= mem1[bus1.mem_raddr];
    end
    assign bus1.mem_rdata = rd1_p;

    always @(posedge clk) begin
        if (rst2) begin
            for (int i = 0; i < 32; i++) mem2[i] <= DW'(i * 10);
        end else if (bus2.mem_wen) begin
            mem2[bus2.mem_waddr] <= bus2.mem_wdata;
        end
        rd2_p[0] <= mem2[bus2.mem_raddr];
        for (int i = 1; i < 4; i++) rd2_p[i] <= rd2_p[i-1];
    end
    assign bus2.mem_rdata = rd2_p[3];

    typedef struct {
        logic          stall;
        logic          ren;
        logic [AW-1:0] raddr;
        logic          wen;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic          exp_mwen;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic st, input logic rn, input int ra,
                                input logic wn, input int wa, input int wd,
                                input logic ev, input int ed, input logic emw);
        vec_t v;
        v.stall     = st;
        v.ren       = rn;
        v.raddr     = AW'(ra);
        v.wen       = wn;
        v.waddr     = AW'(wa);
        v.wdata     = DW'(wd);
        v.exp_valid = ev;
        v.exp_data  = DW'(ed);
        v.exp_mwen  = emw;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_no_full_push();
        checks++;
        if ((u_dut1.w_push_req && u_dut1.w_fifo_full) || (u_dut2.w_push_req && u_dut2.w_fifo_full)) begin
            errors++;
            $display("FAIL push_when_full: got 1, expected 0 at %0t", $time);
        end
    endtask

    task automatic drive1(input logic st, input logic rn, input logic [AW-1:0] ra,
                          input logic wn, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        bus1.global_stall = st;
        bus1.core_ren     = rn;
        bus1.core_raddr   = ra;
        bus1.core_wen     = wn;
        bus1.core_waddr   = wa;
        bus1.core_wdata   = wd;
    endtask

    // One cycle on instance 2: drive, check at negedge, advance past posedge.
    task automatic step2(input string name, input logic r, input logic st, input logic rn,
                         input int ra, input logic ev, input int ed, input logic erdy,
                         input logic eov);
        rst2                = r;
        bus2.global_stall   = st;
        bus2.core_ren       = rn;
        bus2.core_raddr     = AW'(ra);
        bus2.core_wen       = 1'b0;
        bus2.core_waddr     = '0;
        bus2.core_wdata     = '0;
        @(negedge clk);
        check({name, "_valid"}, DW'(bus2.core_rdata_valid), DW'(ev));
        check({name, "_data"},  bus2.core_rdata, DW'(ed));
        check({name, "_ready"}, DW'(bus2.core_req_ready), DW'(erdy));
        check({name, "_ovf"},   DW'(bus2.overflow), DW'(eov));
        check_no_full_push();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Instance 1 cycle table (RD_LAT=1), data = 10*addr.
        tbl[0]  = mk(0, 1, 1, 0, 0, 0,  0, 0,  0);  // unstalled read addr 1
        tbl[1]  = mk(0, 0, 0, 0, 0, 0,  1, 10, 0);  // delivered one cycle later
        tbl[2]  = mk(0, 0, 0, 0, 0, 0,  0, 10, 0);  // data held, valid low
        tbl[3]  = mk(0, 1, 2, 0, 0, 0,  0, 10, 0);  // read addr 2
        tbl[4]  = mk(1, 0, 0, 0, 0, 0,  0, 10, 0);  // returns during stall
        tbl[5]  = mk(1, 0, 0, 0, 0, 0,  0, 10, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 0,  0, 10, 0);
        tbl[7]  = mk(1, 1, 1, 0, 0, 0,  0, 10, 0);  // stalled request ignored
        tbl[8]  = mk(0, 0, 0, 0, 0, 0,  1, 20, 0);  // replay from buffer
        tbl[9]  = mk(0, 0, 0, 0, 0, 0,  0, 20, 0);
        tbl[10] = mk(0, 1, 1, 0, 0, 0,  0, 20, 0);
        tbl[11] = mk(0, 1, 2, 0, 0, 0,  1, 10, 0);  // bypass plus new accept
        tbl[12] = mk(1, 0, 0, 0, 0, 0,  0, 10, 0);  // addr 2 data buffered
        tbl[13] = mk(0, 1, 1, 0, 0, 0,  1, 20, 0);  // pop plus new accept
        tbl[14] = mk(0, 0, 0, 0, 0, 0,  1, 10, 0);  // bypass of addr 1
        tbl[15] = mk(0, 0, 0, 0, 0, 0,  0, 10, 0);
        tbl[16] = mk(1, 0, 0, 1, 0, 20, 0, 10, 0);  // write blocked by stall
        tbl[17] = mk(0, 0, 0, 1, 0, 20, 0, 10, 1);  // write goes through
        tbl[18] = mk(0, 1, 0, 0, 0, 0,  0, 10, 0);  // read back addr 0
        tbl[19] = mk(0, 0, 0, 0, 0, 0,  1, 20, 0);

        rst1 = 1'b1;
        rst2 = 1'b1;
        drive1(0, 0, '0, 0, '0, '0);
        bus2.global_stall = 1'b0;
        bus2.core_ren     = 1'b0;
        bus2.core_raddr   = '0;
        bus2.core_wen     = 1'b0;
        bus2.core_waddr   = '0;
        bus2.core_wdata   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst1 = 1'b0;
        rst2 = 1'b0;

        @(negedge clk);
        check("rst1_valid", DW'(bus1.core_rdata_valid), '0);
        check("rst1_data",  bus1.core_rdata, '0);
        check("rst1_ready", DW'(bus1.core_req_ready), DW'(1));
        check("rst1_ovf",   DW'(bus1.overflow), '0);
        check("rst2_valid", DW'(bus2.core_rdata_valid), '0);
        check("rst2_ovf",   DW'(bus2.overflow), '0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            drive1(tbl[i].stall, tbl[i].ren, tbl[i].raddr, tbl[i].wen, tbl[i].waddr, tbl[i].wdata);
            @(negedge clk);
            check($sformatf("row%0d_valid", i), DW'(bus1.core_rdata_valid), DW'(tbl[i].exp_valid));
            check($sformatf("row%0d_data", i),  bus1.core_rdata, tbl[i].exp_data);
            check($sformatf("row%0d_mwen", i),  DW'(bus1.mem_wen), DW'(tbl[i].exp_mwen));
            check($sformatf("row%0d_ready", i), DW'(bus1.core_req_ready), DW'(1));
            check($sformatf("row%0d_ovf", i),   DW'(bus1.overflow), '0);
            if (tbl[i].wen) begin
                check($sformatf("row%0d_waddr", i), DW'(bus1.mem_waddr), DW'(tbl[i].waddr));
                check($sformatf("row%0d_wdata", i), bus1.mem_wdata, tbl[i].wdata);
            end
            check_no_full_push();
            @(posedge clk);
            #1;
        end
        drive1(0, 0, '0, 0, '0, '0);

        // Instance 2 (RD_LAT=4): four reads, stall while all four return,
        // then a request against the full buffer.
        step2("f0",  0, 0, 1, 1, 0, 0,  1, 0);
        step2("f1",  0, 0, 1, 2, 0, 0,  1, 0);
        step2("f2",  0, 0, 1, 3, 0, 0,  1, 0);
        step2("f3",  0, 0, 1, 4, 0, 0,  1, 0);
        step2("f4",  0, 1, 0, 0, 0, 0,  0, 0);
        step2("f5",  0, 1, 0, 0, 0, 0,  0, 0);
        step2("f6",  0, 1, 0, 0, 0, 0,  0, 0);
        step2("f7",  0, 1, 0, 0, 0, 0,  0, 0);
        step2("f8",  0, 0, 1, 1, 1, 10, 0, 0);
        step2("f9",  0, 0, 0, 0, 1, 20, 1, 1);
        step2("f10", 0, 0, 0, 0, 1, 30, 1, 1);
        step2("f11", 0, 0, 0, 0, 1, 40, 1, 1);
        step2("f12", 0, 0, 0, 0, 0, 40, 1, 1);
        // Replay while the next response arrives in the same cycle.
        step2("p13", 0, 0, 1, 2, 0, 40, 1, 1);
        step2("p14", 0, 0, 1, 3, 0, 40, 1, 1);
        step2("p15", 0, 1, 0, 0, 0, 40, 1, 1);
        step2("p16", 0, 1, 0, 0, 0, 40, 1, 1);
        step2("p17", 0, 1, 0, 0, 0, 40, 1, 1);
        step2("p18", 0, 0, 0, 0, 1, 20, 1, 1);
        step2("p19", 0, 0, 0, 0, 1, 30, 1, 1);
        step2("p20", 0, 0, 0, 0, 0, 30, 1, 1);
        // Reset with a read in flight: its data must never be delivered.
        step2("r21", 0, 0, 1, 4, 0, 30, 1, 1);
        step2("r22", 1, 0, 0, 0, 0, 30, 1, 1);
        step2("r23", 0, 0, 0, 0, 0, 0,  1, 0);
        step2("r24", 0, 0, 0, 0, 0, 0,  1, 0);
        step2("r25", 0, 0, 0, 0, 0, 0,  1, 0);
        step2("r26", 0, 0, 0, 0, 0, 0,  1, 0);
        step2("r27", 0, 0, 0, 0, 0, 0,  1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
